// File: rtl/nand_full_adder_pkg.sv
// Shared helpers for the nand2adder family: behavioural reference arithmetic
// used by the built-in checker.
package nand_full_adder_pkg;

    // Two-bit behavioural sum of three 1-bit operands; no truncation.
    function automatic logic [1:0] behav_sum(input logic a, input logic b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {1'b0, cin};
    endfunction

endpackage

// File: rtl/nand_full_adder_nand2.sv
// Two-input NAND primitive; the only gate allowed on the adder's S/Cout path.
module nand2 (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a & b);

endmodule

// File: rtl/nand_full_adder.sv
// 1-bit full adder built from nine NAND2 gates, with registered outputs and a
// sticky self-checker comparing the gate network against a behavioural sum.
module nand_full_adder
    import nand_full_adder_pkg::*;
#(
    parameter bit CHECK_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout,
    output logic S_q,
    output logic Cout_q,
    output logic err
);

    logic n1, n2, n3, x, n5, n6, n7;
    logic sum_n, cout_n;

    // x = A ^ B
    nand2 u_n1 (.a(A),   .b(B),   .y(n1));
    nand2 u_n2 (.a(A),   .b(n1),  .y(n2));
    nand2 u_n3 (.a(B),   .b(n1),  .y(n3));
    nand2 u_n4 (.a(n2),  .b(n3),  .y(x));
    // S = x ^ Cin, Cout = ~(n1 & n5)
    nand2 u_n5 (.a(x),   .b(Cin), .y(n5));
    nand2 u_n6 (.a(x),   .b(n5),  .y(n6));
    nand2 u_n7 (.a(Cin), .b(n5),  .y(n7));
    nand2 u_n8 (.a(n6),  .b(n7),  .y(sum_n));
    nand2 u_n9 (.a(n1),  .b(n5),  .y(cout_n));

    assign S    = sum_n;
    assign Cout = cout_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_q    <= 1'b0;
            Cout_q <= 1'b0;
        end else begin
            S_q    <= sum_n;
            Cout_q <= cout_n;
        end
    end

    generate
        if (CHECK_EN) begin : g_check
            logic err_r;

            // Case inequality so an X/Z anywhere in the compare flags a mismatch.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    err_r <= 1'b0;
                end else if ({cout_n, sum_n} !== behav_sum(A, B, Cin)) begin
                    err_r <= 1'b1;
                end
            end

            assign err = err_r;
        end else begin : g_no_check
            assign err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_nand_full_adder.sv
// Self-checking bench for nand_full_adder: checker-enabled and checker-disabled
// instances driven from shared inputs and compared against an arithmetic model.
module tb_nand_full_adder;

    logic clk;
    logic rst_n;
    logic a, b, cin;
    logic s1, c1, sq1, cq1, err1;
    logic s0, c0, sq0, cq0, err0;

    int checks;
    int errors;

    nand_full_adder #(.CHECK_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Cin(cin),
        .S(s1), .Cout(c1), .S_q(sq1), .Cout_q(cq1), .err(err1)
    );

    nand_full_adder #(.CHECK_EN(1'b0)) dut_nochk (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Cin(cin),
        .S(s0), .Cout(c0), .S_q(sq0), .Cout_q(cq0), .err(err0)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer addition of the three operand bits.
    function automatic int ref_sum(input logic ia, input logic ib, input logic ic);
        return int'(ia) + int'(ib) + int'(ic);
    endfunction

    task automatic test_reset();
        int e;
        a = 1'b1; b = 1'b0; cin = 1'b1;
        #1;
        e = ref_sum(a, b, cin);
        checks++;
        if ({cq1, sq1, err1} !== 3'b000) begin
            errors++;
            $display("FAIL reset_regs: got Cout_q,S_q,err=%b%b%b want 000", cq1, sq1, err1);
        end
        checks++;
        if ({c1, s1} !== 2'(e)) begin
            errors++;
            $display("FAIL reset_comb: got %b%b want %0d", c1, s1, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_comb_exhaustive();
        logic [2:0] v;
        int e;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a, b, cin} = v;
            #1;
            e = ref_sum(v[2], v[1], v[0]);
            checks++;
            if ({c1, s1} !== 2'(e)) begin
                errors++;
                $display("FAIL comb_%b: got Cout,S=%b%b want %0d", v, c1, s1, e);
            end
            checks++;
            if ({c0, s0} !== 2'(e)) begin
                errors++;
                $display("FAIL comb_nochk_%b: got Cout,S=%b%b want %0d", v, c0, s0, e);
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        {a, b, cin} = 3'b110;
        @(posedge clk); #1;
        checks++;
        if ({cq1, sq1} !== 2'b10) begin
            errors++;
            $display("FAIL reg_110: got Cout_q,S_q=%b%b want 10", cq1, sq1);
        end
        @(negedge clk);
        {a, b, cin} = 3'b111;
        @(posedge clk); #1;
        checks++;
        if ({cq1, sq1} !== 2'b11) begin
            errors++;
            $display("FAIL reg_111: got Cout_q,S_q=%b%b want 11", cq1, sq1);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cq1, sq1, err1} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: got Cout_q,S_q,err=%b%b%b want 000", cq1, sq1, err1);
        end
        checks++;
        if ({c1, s1} !== 2'b11) begin
            errors++;
            $display("FAIL async_reset_comb: got Cout,S=%b%b want 11", c1, s1);
        end
    endtask

    task automatic test_reset_release();
        @(negedge clk);
        rst_n = 1'b1;
        {a, b, cin} = 3'b011;
        @(posedge clk); #1;
        checks++;
        if ({cq1, sq1} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got Cout_q,S_q=%b%b want 10", cq1, sq1);
        end
    endtask

    task automatic test_checker();
        @(negedge clk);
        {a, b, cin} = 3'b111;
        force dut.cout_n = 1'b0;
        force dut_nochk.cout_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (err1 !== 1'b1) begin
            errors++;
            $display("FAIL checker_set: got err=%b want 1", err1);
        end
        checks++;
        if (err0 !== 1'b0) begin
            errors++;
            $display("FAIL nochk_set: got err=%b want 0", err0);
        end
        @(negedge clk);
        release dut.cout_n;
        release dut_nochk.cout_n;
        @(posedge clk); #1;
        checks++;
        if (err1 !== 1'b1) begin
            errors++;
            $display("FAIL checker_sticky: got err=%b want 1", err1);
        end
        checks++;
        if (err0 !== 1'b0) begin
            errors++;
            $display("FAIL nochk_sticky: got err=%b want 0", err0);
        end
        checks++;
        if ({cq1, sq1} !== 2'b11) begin
            errors++;
            $display("FAIL after_release_reg: got Cout_q,S_q=%b%b want 11", cq1, sq1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (err1 !== 1'b0) begin
            errors++;
            $display("FAIL checker_clear: got err=%b want 0", err1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int e;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            a = 1'($urandom); b = 1'($urandom); cin = 1'($urandom);
            e = ref_sum(a, b, cin);
            #1;
            checks++;
            if ({c1, s1} !== 2'(e)) begin
                errors++;
                $display("FAIL rand_comb[%0d]: got Cout,S=%b%b want %0d", i, c1, s1, e);
            end
            @(posedge clk); #1;
            checks++;
            if ({cq1, sq1, err1} !== {2'(e), 1'b0}) begin
                errors++;
                $display("FAIL rand_reg[%0d]: got Cout_q,S_q,err=%b%b%b want %0d,0", i, cq1, sq1, err1, e);
            end
            if ($urandom_range(0, 9) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                checks++;
                if ({cq1, sq1, cq0, sq0} !== 4'b0000) begin
                    errors++;
                    $display("FAIL rand_reset[%0d]: got %b%b%b%b want 0000", i, cq1, sq1, cq0, sq0);
                end
                #1;
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        a = 1'b0; b = 1'b0; cin = 1'b0;
        test_reset();
        test_comb_exhaustive();
        test_registered();
        test_async_reset();
        test_reset_release();
        test_checker();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
